// File: rtl/emu_time_sched_if.sv
// Bundle for the emulated-time scheduler. The master side drives the scheduling inputs;
// the slave side is the scheduler itself.
interface emu_time_sched_if #(
  parameter int NUM_CLKS   = 4,
  parameter int TIME_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  localparam int IDX_WIDTH = $clog2(NUM_CLKS);

  logic                           run;
  logic                           stop_en;
  logic [TIME_WIDTH-1:0]          stop_time;
  logic [NUM_CLKS-1:0]            clk_valid;
  logic [NUM_CLKS*TIME_WIDTH-1:0] time_clocks;
  logic [TIME_WIDTH-1:0]          time_next;
  logic                           emu_clk_en;
  logic [IDX_WIDTH-1:0]           winner;
  logic [CNT_WIDTH-1:0]           step_count;
  logic                           busy;
  logic                           done;
  logic                           err;

  modport master (
    output run, stop_en, stop_time, clk_valid, time_clocks,
    input  time_next, emu_clk_en, winner, step_count, busy, done, err
  );

  modport slave (
    input  run, stop_en, stop_time, clk_valid, time_clocks,
    output time_next, emu_clk_en, winner, step_count, busy, done, err
  );
endinterface

// File: rtl/emu_time_sched.sv
// Emulated-time scheduler: scans one generator per cycle for the earliest valid next edge,
// then commits it as the global time with a one-cycle step strobe.
module emu_time_sched #(
  parameter int NUM_CLKS   = 4,
  parameter int TIME_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic             clk_sys,
  input  logic             rst,
  emu_time_sched_if.slave  sched
);
  localparam int IDX_W = $clog2(NUM_CLKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLKS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [IDX_W-1:0]      scan_idx;
  logic [IDX_W-1:0]      min_idx;
  logic [TIME_WIDTH-1:0] min_time;
  logic                  min_seen;

  logic [TIME_WIDTH-1:0] cur_time;
  logic                  cur_valid;
  logic                  take_cur;
  logic                  brk_hit;

  logic [TIME_WIDTH-1:0] time_next_r;
  logic                  emu_clk_en_r;
  logic [IDX_W-1:0]      winner_r;
  logic [CNT_WIDTH-1:0]  step_count_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;

  assign cur_time  = sched.time_clocks[int'(scan_idx)*TIME_WIDTH +: TIME_WIDTH];
  assign cur_valid = sched.clk_valid[scan_idx];
  // Strict less-than keeps the lowest index on ties.
  assign take_cur  = cur_valid && (!min_seen || (cur_time < min_time));
  assign brk_hit   = sched.stop_en && (min_time > sched.stop_time);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sched.run) state_nxt = ST_SCAN;
      ST_SCAN:   if (scan_idx == LAST_IDX) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        if (!min_seen || brk_hit) state_nxt = ST_HALT;
        else if (sched.run)       state_nxt = ST_SCAN;
        else                      state_nxt = ST_IDLE;
      end
      ST_HALT:   if (!sched.run) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state        <= ST_IDLE;
      scan_idx     <= '0;
      min_idx      <= '0;
      min_time     <= '0;
      min_seen     <= 1'b0;
      time_next_r  <= '0;
      emu_clk_en_r <= 1'b0;
      winner_r     <= '0;
      step_count_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state        <= state_nxt;
      emu_clk_en_r <= 1'b0;
      // Status flags follow the state being entered so they stay registered.
      busy_r       <= (state_nxt == ST_SCAN) || (state_nxt == ST_COMMIT);
      case (state)
        ST_IDLE: begin
          scan_idx <= '0;
          min_seen <= 1'b0;
        end
        ST_SCAN: begin
          if (take_cur) begin
            min_time <= cur_time;
            min_idx  <= scan_idx;
            min_seen <= 1'b1;
          end
          scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
        end
        ST_COMMIT: begin
          scan_idx <= '0;
          min_seen <= 1'b0;
          if (!min_seen) begin
            err_r <= 1'b1;
          end else if (brk_hit) begin
            done_r <= 1'b1;
          end else begin
            time_next_r  <= min_time;
            winner_r     <= min_idx;
            emu_clk_en_r <= 1'b1;
            if (step_count_r != '1) step_count_r <= step_count_r + CNT_WIDTH'(1);
          end
        end
        ST_HALT: begin
          if (!sched.run) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sched.time_next  = time_next_r;
  assign sched.emu_clk_en = emu_clk_en_r;
  assign sched.winner     = winner_r;
  assign sched.step_count = step_count_r;
  assign sched.busy       = busy_r;
  assign sched.done       = done_r;
  assign sched.err        = err_r;
endmodule

// File: tb/tb_emu_time_sched.sv
// Directed and randomized checks of emu_time_sched against a step-level reference model.
module tb_emu_time_sched;
  localparam int N  = 4;
  localparam int TW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  emu_time_sched_if #(.NUM_CLKS(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW)) sched ();

  emu_time_sched #(.NUM_CLKS(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW)) u_dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .sched   (sched)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [TW-1:0] m_time;
  int            m_count;
  int            m_winner;
  bit            plan_v [N];
  logic [TW-1:0] plan_t [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_gen(input int i, input bit v, input logic [TW-1:0] t);
    sched.clk_valid[i] = v;
    sched.time_clocks[i*TW +: TW] = t;
  endtask

  task automatic garbage_all();
    for (int j = 0; j < N; j++) set_gen(j, 1'($urandom), TW'($urandom_range(0, 50)));
  endtask

  task automatic chk_model(input string pfx);
    chk({pfx, "_time"},  sched.time_next,  m_time);
    chk({pfx, "_winner"}, sched.winner,    m_winner);
    chk({pfx, "_count"}, sched.step_count, m_count);
  endtask

  task automatic enter_scan();
    sched.run = 1'b1;
    tick();
    chk("enter_busy", sched.busy, 1);
    chk("enter_strobe", sched.emu_clk_en, 0);
  endtask

  // Leaves HALT: hold with run high (flags stay), then drop run -> IDLE with flags cleared.
  task automatic leave_halt();
    if (sched.run) begin
      tick();
      chk("halt_hold_busy", sched.busy, 0);
      chk("halt_hold_strobe", sched.emu_clk_en, 0);
      sched.run = 1'b0;
    end
    tick();
    chk("halt_exit_done", sched.done, 0);
    chk("halt_exit_err", sched.err, 0);
    chk("halt_exit_busy", sched.busy, 0);
  endtask

  // One full step: generator i is presented with its planned value only in the cycle it is
  // scanned; every other slot carries garbage. outcome: 0 = continues scanning, 1 = idle, 2 = halt.
  task automatic do_step(input int drop_at, input bit rst_commit, output int outcome);
    bit any;
    logic [TW-1:0] mn;
    int w;
    for (int i = 0; i < N; i++) begin
      garbage_all();
      set_gen(i, plan_v[i], plan_t[i]);
      if (i == drop_at) sched.run = 1'b0;
      tick();
      chk("scan_busy", sched.busy, 1);
      chk("scan_strobe", sched.emu_clk_en, 0);
    end
    garbage_all();
    if (rst_commit) rst = 1'b1;
    tick();
    if (rst_commit) begin
      rst = 1'b0;
      m_time = '0; m_count = 0; m_winner = 0;
      chk("rst_commit_strobe", sched.emu_clk_en, 0);
      chk("rst_commit_busy", sched.busy, 0);
      chk("rst_commit_done", sched.done, 0);
      chk("rst_commit_err", sched.err, 0);
      chk_model("rst_commit");
      outcome = 1;
      return;
    end
    any = 1'b0;
    mn = '1;
    for (int i = 0; i < N; i++)
      if (plan_v[i]) begin
        any = 1'b1;
        if (plan_t[i] < mn) mn = plan_t[i];
      end
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && plan_v[i] && plan_t[i] == mn) w = i;
    if (!any) begin
      chk("halt_err", sched.err, 1);
      chk("halt_err_done", sched.done, 0);
      chk("halt_err_strobe", sched.emu_clk_en, 0);
      chk("halt_err_busy", sched.busy, 0);
      outcome = 2;
    end else if (sched.stop_en && mn > sched.stop_time) begin
      chk("halt_done", sched.done, 1);
      chk("halt_done_err", sched.err, 0);
      chk("halt_done_strobe", sched.emu_clk_en, 0);
      chk("halt_done_busy", sched.busy, 0);
      outcome = 2;
    end else begin
      m_time = mn;
      m_winner = w;
      if (m_count < CNT_MAX) m_count++;
      chk("commit_strobe", sched.emu_clk_en, 1);
      chk("commit_busy", sched.busy, {63'b0, sched.run});
      chk("commit_done", sched.done, 0);
      chk("commit_err", sched.err, 0);
      outcome = sched.run ? 0 : 1;
    end
    chk_model("step");
  endtask

  task automatic recover(input int outcome);
    if (outcome == 2) begin
      leave_halt();
      enter_scan();
    end else if (outcome == 1) begin
      enter_scan();
    end
  endtask

  initial begin
    int oc;
    int drop;
    bit rc;

    rst = 1'b1;
    sched.run = 1'b0;
    sched.stop_en = 1'b0;
    sched.stop_time = '0;
    sched.clk_valid = '0;
    sched.time_clocks = '0;
    m_time = '0; m_count = 0; m_winner = 0;
    tick();
    tick();
    chk("reset_strobe", sched.emu_clk_en, 0);
    chk("reset_busy", sched.busy, 0);
    chk("reset_done", sched.done, 0);
    chk("reset_err", sched.err, 0);
    chk_model("reset");
    rst = 1'b0;
    tick();
    chk("idle_stays", sched.busy, 0);

    // Basic step with a tie at the minimum
    plan_v = '{1, 1, 1, 1};
    plan_t = '{40, 25, 60, 25};
    enter_scan();
    do_step(-1, 1'b0, oc);
    chk("basic_time", sched.time_next, 25);
    chk("basic_winner", sched.winner, 1);
    chk("basic_count", sched.step_count, 1);

    // Inclusive breakpoint, then a minimum one past it
    sched.stop_en = 1'b1;
    sched.stop_time = 100;
    plan_t = '{100, 200, 300, 400};
    do_step(-1, 1'b0, oc);
    chk("brk_equal_time", sched.time_next, 100);
    plan_t = '{150, 101, 300, 400};
    do_step(-1, 1'b0, oc);
    chk("brk_over_done", sched.done, 1);
    chk("brk_over_time", sched.time_next, 100);
    leave_halt();
    sched.stop_en = 1'b0;

    // Run dropped during the second scan cycle
    plan_t = '{7, 3, 9, 5};
    enter_scan();
    do_step(1, 1'b0, oc);
    chk("drop_outcome_idle", oc, 1);
    tick();
    chk("drop_idle_busy", sched.busy, 0);
    chk("drop_idle_strobe", sched.emu_clk_en, 0);

    // Reset landing on the commit cycle
    enter_scan();
    do_step(-1, 1'b1, oc);

    // No valid generator
    plan_v = '{0, 0, 0, 0};
    enter_scan();
    do_step(-1, 1'b0, oc);
    chk("novalid_time", sched.time_next, 0);
    leave_halt();

    // Saturating step counter
    plan_v = '{1, 1, 1, 1};
    enter_scan();
    for (int s = 0; s < CNT_MAX + 2; s++) begin
      for (int i = 0; i < N; i++) plan_t[i] = TW'($urandom_range(0, 1000));
      do_step(-1, 1'b0, oc);
    end
    chk("count_saturated", sched.step_count, CNT_MAX);

    // Randomized steps
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < N; i++) plan_v[i] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) plan_v[i] = ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < N; i++)
        plan_t[i] = ($urandom_range(0, 3) == 0) ? TW'($urandom) : TW'($urandom_range(0, 40));
      sched.stop_en = ($urandom_range(0, 2) == 0);
      sched.stop_time = TW'($urandom_range(0, 40));
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      rc = ($urandom_range(0, 19) == 0);
      do_step(drop, rc, oc);
      recover(oc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/emu_time_sched.md
EMU_TIME_SCHED -- requirements
Module: emu_time_sched

Interface
REQ-001 Parameter NUM_CLKS, default 4: number of emulated clock generators scheduled; legal range 2..16.
REQ-002 Parameter TIME_WIDTH, default 32: width of every emulated-time value.
REQ-003 Parameter CNT_WIDTH, default 32: width of the step counter.
REQ-004 clk_sys  input  1  system clock; one clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 run  input  1  level; high = keep scheduling steps, low = stop after the current step.
REQ-007 stop_en  input  1  enables the stop_time breakpoint.
REQ-008 stop_time  input  TIME_WIDTH  breakpoint time; unsigned.
REQ-009 clk_valid  input  NUM_CLKS  bit i high = generator i participates in scheduling.
REQ-010 time_clocks  input  NUM_CLKS*TIME_WIDTH  packed; slice i = next edge time of generator i; unsigned.
REQ-011 time_next  output  TIME_WIDTH  committed global emulated time, broadcast to all generators.
REQ-012 emu_clk_en  output  1  one-cycle strobe marking a committed time step.
REQ-013 winner  output  $clog2(NUM_CLKS)  index of the generator that set the last committed time.
REQ-014 step_count  output  CNT_WIDTH  number of committed steps since reset.
REQ-015 busy  output  1  high in SCAN and COMMIT.
REQ-016 done  output  1  high in HALT because of the breakpoint.
REQ-017 err  output  1  high in HALT because no generator was valid.

Function
REQ-018 FSM states SHALL be IDLE, SCAN, COMMIT and HALT.
REQ-019 IDLE -> SCAN when run=1; otherwise stay in IDLE.
REQ-020 SCAN SHALL examine one generator per cycle at indices 0..NUM_CLKS-1 and SHALL track the running minimum and its index over valid generators only.
REQ-021 Comparison SHALL be unsigned strict-less-than, so on ties the lowest index wins.
REQ-022 clk_valid and time_clocks SHALL be sampled at the cycle their index is scanned; later changes SHALL not affect that step.
REQ-023 After index NUM_CLKS-1, SCAN -> COMMIT; a step SHALL therefore take exactly NUM_CLKS+1 cycles from entering SCAN to the emu_clk_en strobe.
REQ-024 In COMMIT with no valid generator seen: go to HALT, set err=1, leave time_next/step_count/winner unchanged, and do not strobe.
REQ-025 In COMMIT with stop_en=1 and minimum > stop_time: go to HALT, set done=1, leave time_next unchanged, and do not strobe.
REQ-026 Otherwise in COMMIT: set time_next to the minimum, winner to the min index, step_count+1 (saturating at all-ones), emu_clk_en=1 for that cycle; then -> SCAN if run=1, else -> IDLE.
REQ-027 A minimum equal to stop_time SHALL commit, so the breakpoint is inclusive.
REQ-028 When run deasserts during SCAN, the in-flight step SHALL complete per REQ-024..026.
REQ-029 HALT -> IDLE when run=0, clearing done and err; while run=1, stay in HALT.
REQ-030 A minimum smaller than the current time_next SHALL still commit; no monotonicity check.
REQ-031 Outputs SHALL be registered; emu_clk_en SHALL never be high for two consecutive cycles.

Reset
REQ-032 While rst=1 at a clk_sys edge: state=IDLE, time_next=0, winner=0, step_count=0, emu_clk_en=0, busy=0, done=0, err=0, scan index and running minimum cleared.
REQ-033 rst SHALL take priority over all transitions, including mid-SCAN and in COMMIT; no strobe is issued in the reset cycle.

Verification
REQ-034 NUM_CLKS=4, all valid, times {40,25,60,25}, run held high -> emu_clk_en strobe 5 cycles after leaving IDLE, time_next=25, winner=1, step_count=1.
REQ-035 clk_valid=4'b0000, run=1 -> HALT after 5 cycles, err=1, no strobe, time_next=0; then run=0 -> IDLE, err=0.
REQ-036 stop_en=1 with stop_time=100: minimum 100 -> commits; next minimum 101 -> HALT, done=1, time_next stays 100.
REQ-037 run dropped on the 2nd SCAN cycle -> step completes with one strobe, then IDLE, busy=0.
REQ-038 rst asserted in COMMIT cycle -> no strobe, all outputs return to zero, state IDLE.
REQ-039 step_count preloaded to all-ones via a small CNT_WIDTH build (CNT_WIDTH=4, 16 steps) -> count holds 15.
